// File: rtl/req_arbiter.sv
// Round-robin request arbiter feeding the scoreboard's single request port.
// Holds one request per FSM; memory-class opcodes wait for a free bank and never issue back to back.
module req_arbiter #(
  parameter int                           SRC_ID_W      = 4,
  parameter int                           NUM_REQ       = 2,
  parameter int                           OPCODE_W      = 2,
  parameter logic [SRC_ID_W*NUM_REQ-1:0]  REQ_SRC_IDS   = '0,
  parameter logic [OPCODE_W-1:0]          MEM_RD_OPCODE = '0,
  parameter logic [OPCODE_W-1:0]          MEM_WA_OPCODE = OPCODE_W'(1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           fsm_req_valid,
  input  logic [OPCODE_W*NUM_REQ-1:0]  fsm_req_opcode,
  output logic [NUM_REQ-1:0]           fsm_req_ready,
  output logic [NUM_REQ-1:0]           fsm_issued,
  input  logic                         mem_ready,
  output logic                         req_valid,
  output logic [SRC_ID_W-1:0]          req_src_id,
  output logic [OPCODE_W-1:0]          req_opcode
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic is_mem(input logic [OPCODE_W-1:0] op);
    return (op == MEM_RD_OPCODE) || (op == MEM_WA_OPCODE);
  endfunction

  logic [NUM_REQ-1:0]  pending;
  logic [NUM_REQ-1:0]  eligible;
  logic [OPCODE_W-1:0] slot_op [NUM_REQ];
  logic [SRC_ID_W-1:0] src_id  [NUM_REQ];

  logic                req_valid_reg;
  logic [SRC_ID_W-1:0] req_src_id_reg;
  logic [OPCODE_W-1:0] req_opcode_reg;
  logic [NUM_REQ-1:0]  fsm_issued_reg;
  logic [RR_W-1:0]     rr_reg;

  logic                win_found;
  logic [RR_W-1:0]     win_idx;
  logic [RR_W-1:0]     rr_next;
  logic                mem_open;

  // The scoreboard's mem_ready lags one cycle behind a memory issue, so block right after one.
  assign mem_open = mem_ready && !(req_valid_reg && is_mem(req_opcode_reg));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      logic                pending_reg;
      logic [OPCODE_W-1:0] opcode_reg;
      logic                accept;
      logic                issue;

      assign src_id[gi]  = REQ_SRC_IDS[gi*SRC_ID_W +: SRC_ID_W];
      assign accept      = fsm_req_valid[gi] && !pending_reg;
      assign issue       = win_found && (win_idx == RR_W'(gi));
      assign pending[gi] = pending_reg;
      assign slot_op[gi] = opcode_reg;
      assign eligible[gi] = pending_reg && (!is_mem(opcode_reg) || mem_open);
      assign fsm_req_ready[gi] = !pending_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pending_reg <= 1'b0;
          opcode_reg  <= '0;
        end else if (accept) begin
          pending_reg <= 1'b1;
          opcode_reg  <= fsm_req_opcode[gi*OPCODE_W +: OPCODE_W];
        end else if (issue) begin
          pending_reg <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = RR_W'(idx);
      end
    end
  end

  assign rr_next = (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + RR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid_reg  <= 1'b0;
      req_src_id_reg <= '0;
      req_opcode_reg <= '0;
      fsm_issued_reg <= '0;
      rr_reg         <= '0;
    end else if (win_found) begin
      req_valid_reg  <= 1'b1;
      req_src_id_reg <= src_id[win_idx];
      req_opcode_reg <= slot_op[win_idx];
      fsm_issued_reg <= NUM_REQ'(1) << win_idx;
      rr_reg         <= rr_next;
    end else begin
      req_valid_reg  <= 1'b0;
      req_src_id_reg <= '0;
      req_opcode_reg <= '0;
      fsm_issued_reg <= '0;
    end
  end

  assign req_valid  = req_valid_reg;
  assign req_src_id = req_src_id_reg;
  assign req_opcode = req_opcode_reg;
  assign fsm_issued = fsm_issued_reg;

endmodule

// File: tb/tb_req_arbiter.sv
// Scoreboard bench for req_arbiter: expected issues are queued at stimulus time and
// matched against every req_valid pulse.
module tb_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] fsm_req_valid;
  logic [3:0] fsm_req_opcode;
  logic [1:0] fsm_req_ready;
  logic [1:0] fsm_issued;
  logic       mem_ready;
  logic       req_valid;
  logic [3:0] req_src_id;
  logic [1:0] req_opcode;

  always #5 clk = ~clk;

  req_arbiter #(
    .SRC_ID_W     (4),
    .NUM_REQ      (2),
    .OPCODE_W     (2),
    .REQ_SRC_IDS  (8'h21),
    .MEM_RD_OPCODE(2'b00),
    .MEM_WA_OPCODE(2'b01)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fsm_req_valid (fsm_req_valid),
    .fsm_req_opcode(fsm_req_opcode),
    .fsm_req_ready (fsm_req_ready),
    .fsm_issued    (fsm_issued),
    .mem_ready     (mem_ready),
    .req_valid     (req_valid),
    .req_src_id    (req_src_id),
    .req_opcode    (req_opcode)
  );

  typedef struct packed {
    logic [3:0] src;
    logic [1:0] op;
    logic [1:0] iss;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [3:0] src, input logic [1:0] op, input logic [1:0] iss);
    exp_t e;
    e.src = src;
    e.op  = op;
    e.iss = iss;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    fsm_req_valid = 2'b00;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check(tag, exp_q.size(), 0);
  endtask

  // Monitor: every issue pulse must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (req_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {28'd0, req_src_id}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        $display("issue t=%0t src=%0h op=%0b issued=%b (exp src=%0h op=%0b issued=%b)",
                 $time, req_src_id, req_opcode, fsm_issued, e.src, e.op, e.iss);
        check("issue_src", req_src_id, e.src);
        check("issue_op", req_opcode, e.op);
        check("issue_oh", fsm_issued, e.iss);
      end
    end
  end

  int left0, left1;

  initial begin
    rst_n          = 1'b0;
    fsm_req_valid  = 2'b00;
    fsm_req_opcode = 4'b0000;
    mem_ready      = 1'b0;

    // Reset values
    cyc();
    cyc();
    check("rst_valid", req_valid, 0);
    check("rst_src", req_src_id, 0);
    check("rst_op", req_opcode, 0);
    check("rst_issued", fsm_issued, 0);
    check("rst_ready", fsm_req_ready, 2'b11);
    rst_n = 1'b1;

    // Single request: FSM0 opcode 2'b10
    mem_ready      = 1'b1;
    fsm_req_valid  = 2'b01;
    fsm_req_opcode = 4'b0010;
    push_exp(4'h1, 2'b10, 2'b01);
    cyc();
    fsm_req_valid = 2'b00;
    check("single_ready_busy", fsm_req_ready, 2'b10);
    check("single_no_early", req_valid, 0);
    cyc();
    check("single_valid", req_valid, 1);
    check("single_ready_back", fsm_req_ready, 2'b11);
    cyc();
    check("single_pulse", req_valid, 0);
    drain("single_drain");

    // Round robin: both request 2'b11 whenever ready, two requests each
    do_reset();
    push_exp(4'h1, 2'b11, 2'b01);
    push_exp(4'h2, 2'b11, 2'b10);
    push_exp(4'h1, 2'b11, 2'b01);
    push_exp(4'h2, 2'b11, 2'b10);
    fsm_req_opcode = 4'b1111;
    left0 = 2;
    left1 = 2;
    for (int i = 0; i < 12; i++) begin
      fsm_req_valid[0] = fsm_req_ready[0] && (left0 > 0);
      fsm_req_valid[1] = fsm_req_ready[1] && (left1 > 0);
      if (fsm_req_valid[0]) left0--;
      if (fsm_req_valid[1]) left1--;
      cyc();
    end
    fsm_req_valid = 2'b00;
    drain("rr_drain");

    // Memory gating: FSM0 memory read held off while mem_ready=0
    do_reset();
    mem_ready      = 1'b0;
    fsm_req_valid  = 2'b11;
    fsm_req_opcode = 4'b1000;
    push_exp(4'h2, 2'b10, 2'b10);
    cyc();
    fsm_req_valid = 2'b00;
    cyc();
    check("gate_fsm1_first", req_valid, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("gate_hold_ready", fsm_req_ready, 2'b10);
      check("gate_hold_idle", req_valid, 0);
    end
    push_exp(4'h1, 2'b00, 2'b01);
    mem_ready = 1'b1;
    cyc();
    check("gate_release", req_valid, 1);
    drain("gate_drain");

    // Back-to-back memory issues need an idle cycle between them
    do_reset();
    mem_ready      = 1'b1;
    fsm_req_valid  = 2'b11;
    fsm_req_opcode = 4'b0100;
    push_exp(4'h1, 2'b00, 2'b01);
    push_exp(4'h2, 2'b01, 2'b10);
    cyc();
    fsm_req_valid = 2'b00;
    cyc();
    check("b2b_first", req_valid, 1);
    cyc();
    check("b2b_gap", req_valid, 0);
    cyc();
    check("b2b_second", req_valid, 1);
    cyc();
    check("b2b_after", req_valid, 0);
    drain("b2b_drain");

    // Reset mid-operation drops pending requests
    do_reset();
    mem_ready      = 1'b0;
    fsm_req_valid  = 2'b11;
    fsm_req_opcode = 4'b0100;
    cyc();
    fsm_req_valid = 2'b00;
    cyc();
    check("mid_pending", fsm_req_ready, 2'b00);
    check("mid_idle", req_valid, 0);
    rst_n = 1'b0;
    cyc();
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    check("mid_ready_cleared", fsm_req_ready, 2'b11);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("mid_no_issue", req_valid, 0);
    end
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter.md
# req_arbiter

Request arbiter that sits directly upstream of the scoreboard. It collects operation requests from the NUM_REQ FSMs (SHA and AES controllers), holds one pending request per FSM, and selects one per cycle round-robin. It presents the winner on the scoreboard's single `req_valid`/`req_src_id`/`req_opcode` port. Memory-claiming opcodes are issued only when the scoreboard reports a free memory bank, and never on two consecutive cycles.

## Interface

- `SRC_ID_W`, 4: width of source IDs.
- `NUM_REQ`, 2: number of requesting FSMs (≥1).
- `OPCODE_W`, 2: opcode width.
- `REQ_SRC_IDS`, 0: packed `SRC_ID_W*NUM_REQ` source IDs; requester i owns bits `[i*SRC_ID_W +: SRC_ID_W]`.
- `MEM_RD_OPCODE`, 2'b00: opcode that claims a memory bank (read); top level binds it to `MEM_OPCODE_READ`.
- `MEM_WA_OPCODE`, 2'b01: opcode that claims a memory bank (write address); top level binds it to `MEM_OPCODE_WRITE_ADDR`.

Ports:

- `clk`, in, 1: clock. One clock only.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `fsm_req_valid`, in, NUM_REQ: per-FSM request valid.
- `fsm_req_opcode`, in, OPCODE_W*NUM_REQ: per-FSM opcode, packed like `REQ_SRC_IDS`.
- `fsm_req_ready`, out, NUM_REQ: per-FSM ready. Combinational; high when that FSM's holding slot is empty.
- `fsm_issued`, out, NUM_REQ: registered one-hot pulse. High in the same cycle the FSM's request appears on `req_valid`.
- `mem_ready`, in, 1: scoreboard indication that a free memory bank exists.
- `req_valid`, out, 1: registered request valid to the scoreboard.
- `req_src_id`, out, SRC_ID_W: registered source ID of the issued request.
- `req_opcode`, out, OPCODE_W: registered opcode of the issued request.

## Operation

**Holding slots**
- One slot per requester, with fields `pending` and `opcode`.
- Accept on `fsm_req_valid[i] && fsm_req_ready[i]`: set `pending`, capture the opcode.
- `fsm_req_ready[i] = !pending[i]`. There is no same-cycle refill, so a slot issued this cycle shows ready the next cycle.

**Eligibility and selection**
- A request is memory-class if its opcode equals `MEM_RD_OPCODE` or `MEM_WA_OPCODE`.
- Slot i is eligible when `pending[i]` is set and either:
  - it is not memory-class, or
  - `mem_ready && !mem_block`.
- `mem_block = req_valid && (req_opcode is memory-class)`. This blocks a second memory issue while the scoreboard's `mem_ready` is still stale for one cycle.
- Round-robin pointer `rr` (`safe_clog2(NUM_REQ)` bits). The search starts at `rr` and wraps modulo NUM_REQ; the first eligible slot wins.

**Issue (registered)**
- When a winner w exists:
  - `req_valid<=1`, `req_src_id<=REQ_SRC_IDS[w]`, `req_opcode<=slot[w].opcode`.
  - `fsm_issued<=1<<w`, `pending[w]<=0`.
  - `rr<=(w+1) mod NUM_REQ`.
- When there is no winner: `req_valid<=0`, `req_src_id<=0`, `req_opcode<=0`, `fsm_issued<=0`, `rr` holds.
- Ineligible pending slots keep their contents. A blocked memory request never blocks a non-memory request from another slot.
- A slot accepting and issuing in the same cycle is impossible, because accept requires an empty slot.

**Reset**
- When `rst_n=0` at a clock edge: all `pending<=0`, `rr<=0`.
- `req_valid`, `req_src_id`, `req_opcode` and `fsm_issued` all reset to 0.
- Requests in flight are dropped. FSMs must re-request after reset.

## Timing

- Accept at edge E → slot pending during cycle E+1 → `req_valid` high from edge E+1 (1-cycle latency, uncontended).
- `req_valid` is a single-cycle pulse per issue. The scoreboard samples it without backpressure.
- Throughput:
  - One issue per cycle overall.
  - One per requester every 2 cycles.
  - Memory-class issues at most every other cycle.
- `mem_ready` is sampled combinationally in the selection cycle. It has no effect on requests already issued.
- `fsm_req_ready` depends only on slot state, with no combinational path from `fsm_req_valid` or `mem_ready`.

## Test plan

- **Reset values:** hold `rst_n=0` for 2 cycles. Expect `req_valid=0`, `req_src_id=0`, `req_opcode=0`, `fsm_issued=0`, `fsm_req_ready=2'b11`.
- **Single request:** `REQ_SRC_IDS=8'h21`; FSM0 requests opcode 2'b10 at edge 1. Next cycle, expect `req_valid=1`, `req_src_id=4'h1`, `req_opcode=2'b10`, `fsm_issued=2'b01`, `fsm_req_ready[0]=0` for exactly one cycle.
- **Round robin:** both FSMs request opcode 2'b11 every cycle they are ready, starting at `rr=0`. Issue order is src 1, 2, 1, 2; no requester is issued twice in a row while the other is pending.
- **Memory gating:** `mem_ready=0`; FSM0 requests 2'b00 and FSM1 requests 2'b10. Expect FSM1 to issue and FSM0 to stay pending. Raise `mem_ready`; FSM0 issues on the following cycle.
- **Back-to-back memory:** `mem_ready` held at 1; FSM0 requests 2'b00 and FSM1 requests 2'b01 together. Expect issues separated by exactly one idle cycle (`req_valid` 1, 0, 1).
- **Reset mid-operation:** with both slots pending and `mem_ready=0`, pulse `rst_n=0` for one cycle. Then drive `mem_ready=1` with no new requests; expect no `req_valid` ever.
